// File: rtl/onfi_nand_target_if.sv
// ONFI SDR pin bundle between a NAND controller (master) and a flash target (slave).
// The IO bus is split into in/out/oe; an outer wrapper maps it onto the tristate pins.
interface onfi_nand_target_if;
  logic       CE_x_n;
  logic       CLE_x;
  logic       ALE_x;
  logic       WE_x_n;
  logic       RE_x_n;
  logic       WP_x_n;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       io_oe;
  logic       RB_x_n;

  modport master (
    output CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, WP_x_n, io_in,
    input  io_out, io_oe, RB_x_n
  );

  modport slave (
    input  CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, WP_x_n, io_in,
    output io_out, io_oe, RB_x_n
  );
endinterface

// File: rtl/onfi_nand_target.sv
// Cycle-based ONFI SDR NAND target: decodes WE/RE strobes into command, address and data
// cycles, holds a flop-based array plus page register, and models busy time on R/B.
module onfi_nand_target #(
  parameter int unsigned PAGE_BYTES = 16,
  parameter int unsigned PAGES      = 4,
  parameter int unsigned T_R        = 20,
  parameter int unsigned T_PROG     = 50,
  parameter int unsigned T_RST      = 10,
  parameter logic [7:0]  ID0        = 8'h2C,
  parameter logic [7:0]  ID1        = 8'hDA,
  parameter logic [7:0]  ID2        = 8'h90,
  parameter logic [7:0]  ID3        = 8'h95
) (
  input logic                clk,
  input logic                rst,
  onfi_nand_target_if.slave  bus
);
  localparam int unsigned ColW = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
  localparam int unsigned RowW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned CntW = 16;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIdAddr   = 3'd1;
  localparam logic [2:0] StRdAddr   = 3'd2;
  localparam logic [2:0] StProgAddr = 3'd3;
  localparam logic [2:0] StProgData = 3'd4;
  localparam logic [2:0] StBusy     = 3'd5;
  localparam logic [2:0] StOut      = 3'd6;

  localparam logic [1:0] MdId = 2'd0, MdStatus = 2'd1, MdPage = 2'd2;
  localparam logic [1:0] OpRead = 2'd0, OpProg = 2'd1, OpRst = 2'd2;

  logic            we_q, re_q;
  logic [2:0]      state_q, state_d;
  logic [1:0]      mode_q, mode_d, op_q, op_d, addr_cnt_q, addr_cnt_d, idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ColW-1:0] col_q, col_d, ptr_q, ptr_d;
  logic [RowW-1:0] row_q, row_d;
  logic            fail_q, fail_d, wp_conf_q, wp_conf_d;
  logic            stat_busy_q, stat_busy_d, resume_q, resume_d;
  logic            rb_q, rb_d, io_oe_q, io_oe_d;
  logic [7:0]      io_out_q, io_out_d, id_byte, status_byte;
  logic            we_rise, re_fall, re_rise, page_rd;
  logic            do_rst, page_wr, page_load, page_clear, commit;
  logic [7:0]      page_q  [PAGE_BYTES];
  logic [7:0]      array_q [PAGES][PAGE_BYTES];

  assign we_rise = ~bus.CE_x_n & ~we_q & bus.WE_x_n;
  assign re_fall = ~bus.CE_x_n & re_q & ~bus.RE_x_n;
  assign re_rise = ~bus.CE_x_n & ~re_q & bus.RE_x_n;
  // A bare 0x00 after an interrupting status read resumes page output at the old column.
  assign page_rd = (state_q == StOut && mode_q == MdPage) ||
                   (state_q == StRdAddr && resume_q && addr_cnt_q == 2'd0);
  assign status_byte = {bus.WP_x_n, rb_q, rb_q, 4'b0000, fail_q};

  always_comb begin
    unique case (idx_q)
      2'd0:    id_byte = ID0;
      2'd1:    id_byte = ID1;
      2'd2:    id_byte = ID2;
      default: id_byte = ID3;
    endcase
  end

  always_comb begin
    state_d = state_q; mode_d = mode_q; op_d = op_q; addr_cnt_d = addr_cnt_q;
    idx_d = idx_q; cnt_d = cnt_q; col_d = col_q; ptr_d = ptr_q; row_d = row_q;
    fail_d = fail_q; wp_conf_d = wp_conf_q; stat_busy_d = stat_busy_q;
    resume_d = resume_q; rb_d = rb_q; io_oe_d = io_oe_q; io_out_d = io_out_q;
    do_rst = 1'b0; page_wr = 1'b0; page_load = 1'b0; page_clear = 1'b0; commit = 1'b0;

    if (we_rise) begin
      if (bus.CLE_x && !bus.ALE_x) begin
        if (state_q == StBusy) begin
          if (bus.io_in == 8'h70) stat_busy_d = 1'b1;
          else if (bus.io_in == 8'hFF) do_rst = 1'b1;
        end else begin
          case (bus.io_in)
            8'hFF: do_rst = 1'b1;
            8'h90: begin state_d = StIdAddr; resume_d = 1'b0; end
            8'h70: begin
              state_d = StOut;
              mode_d  = MdStatus;
              if (state_q == StOut && mode_q == MdPage) resume_d = 1'b1;
            end
            8'h00: begin state_d = StRdAddr; addr_cnt_d = 2'd0; end
            8'h30: begin
              if (state_q == StRdAddr && addr_cnt_q == 2'd2) begin
                state_d = StBusy; op_d = OpRead; cnt_d = CntW'(T_R - 1);
                rb_d = 1'b0; stat_busy_d = 1'b0; resume_d = 1'b0;
              end
            end
            8'h80: begin state_d = StProgAddr; addr_cnt_d = 2'd0; resume_d = 1'b0; end
            8'h10: begin
              if (state_q == StProgData) begin
                state_d = StBusy; op_d = OpProg; cnt_d = CntW'(T_PROG - 1);
                rb_d = 1'b0; stat_busy_d = 1'b0; wp_conf_d = bus.WP_x_n;
              end
            end
            default: ;
          endcase
        end
      end else if (bus.ALE_x && !bus.CLE_x) begin
        if (state_q == StIdAddr) begin
          if (bus.io_in == 8'h00) begin state_d = StOut; mode_d = MdId; idx_d = 2'd0; end
          else state_d = StIdle;
        end else if (state_q == StRdAddr || state_q == StProgAddr) begin
          resume_d = 1'b0;
          if (addr_cnt_q == 2'd0) begin
            col_d = bus.io_in[ColW-1:0];
            addr_cnt_d = 2'd1;
          end else if (addr_cnt_q == 2'd1) begin
            row_d = bus.io_in[RowW-1:0];
            addr_cnt_d = 2'd2;
            if (state_q == StProgAddr) begin state_d = StProgData; ptr_d = col_q; end
          end
        end
      end else if (!bus.CLE_x && !bus.ALE_x && state_q == StProgData) begin
        page_wr = 1'b1;
        ptr_d   = ptr_q + ColW'(1);
      end
    end else if (re_fall) begin
      if (page_rd) begin
        io_oe_d = 1'b1; io_out_d = page_q[ptr_q];
        state_d = StOut; mode_d = MdPage; resume_d = 1'b0;
      end else if (state_q == StOut && mode_q == MdId) begin
        io_oe_d = 1'b1; io_out_d = id_byte;
      end else if ((state_q == StOut && mode_q == MdStatus) ||
                   (state_q == StBusy && stat_busy_q)) begin
        io_oe_d = 1'b1; io_out_d = status_byte;
      end
    end else if (re_rise) begin
      io_oe_d = 1'b0;
      if (state_q == StOut && mode_q == MdPage) ptr_d = ptr_q + ColW'(1);
      if (state_q == StOut && mode_q == MdId)   idx_d = idx_q + 2'd1;
    end

    if (do_rst) begin
      state_d = StBusy; op_d = OpRst; cnt_d = CntW'(T_RST - 1); rb_d = 1'b0;
      stat_busy_d = 1'b0; resume_d = 1'b0; fail_d = 1'b0; page_clear = 1'b1;
    end else if (state_q == StBusy) begin
      if (cnt_q == '0) begin
        rb_d    = 1'b1;
        state_d = stat_busy_d ? StOut : StIdle;
        mode_d  = MdStatus;
        if (op_q == OpRead) begin
          page_load = 1'b1; ptr_d = col_q; resume_d = stat_busy_d;
          if (!stat_busy_d) begin state_d = StOut; mode_d = MdPage; end
        end else if (op_q == OpProg) begin
          commit = wp_conf_q;
          fail_d = ~wp_conf_q;
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    if (bus.CE_x_n) io_oe_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b1; re_q <= 1'b1; state_q <= StIdle; mode_q <= MdId; op_q <= OpRead;
      addr_cnt_q <= '0; idx_q <= '0; cnt_q <= '0; col_q <= '0; ptr_q <= '0; row_q <= '0;
      fail_q <= 1'b0; wp_conf_q <= 1'b0; stat_busy_q <= 1'b0; resume_q <= 1'b0;
      rb_q <= 1'b1; io_oe_q <= 1'b0; io_out_q <= 8'h00;
      for (int b = 0; b < PAGE_BYTES; b++) page_q[b] <= 8'hFF;
      for (int p = 0; p < PAGES; p++)
        for (int b = 0; b < PAGE_BYTES; b++) array_q[p][b] <= 8'hFF;
    end else begin
      we_q <= bus.WE_x_n; re_q <= bus.RE_x_n; state_q <= state_d; mode_q <= mode_d;
      op_q <= op_d; addr_cnt_q <= addr_cnt_d; idx_q <= idx_d; cnt_q <= cnt_d;
      col_q <= col_d; ptr_q <= ptr_d; row_q <= row_d; fail_q <= fail_d;
      wp_conf_q <= wp_conf_d; stat_busy_q <= stat_busy_d; resume_q <= resume_d;
      rb_q <= rb_d; io_oe_q <= io_oe_d; io_out_q <= io_out_d;
      if (page_clear) begin
        for (int b = 0; b < PAGE_BYTES; b++) page_q[b] <= 8'hFF;
      end else if (page_load) begin
        for (int b = 0; b < PAGE_BYTES; b++) page_q[b] <= array_q[row_q][b];
      end else if (page_wr) begin
        page_q[ptr_q] <= bus.io_in;
      end
      if (commit) begin
        for (int b = 0; b < PAGE_BYTES; b++) array_q[row_q][b] <= page_q[b];
      end
    end
  end

  assign bus.RB_x_n = rb_q;
  assign bus.io_oe  = io_oe_q;
  assign bus.io_out = io_out_q;
endmodule

// File: tb/tb_onfi_nand_target.sv
// Directed bench for onfi_nand_target: a vector table of pin-level operations with
// hand-computed results, plus hand-written busy-status, abort and chip-enable sequences.
module tb_onfi_nand_target;
  localparam int unsigned TR = 20, TP = 50, TRST = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onfi_nand_target_if bus ();

  onfi_nand_target #(
    .PAGE_BYTES(16), .PAGES(4), .T_R(TR), .T_PROG(TP), .T_RST(TRST),
    .ID0(8'h2C), .ID1(8'hDA), .ID2(8'h90), .ID3(8'h95)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum int {KCmd, KAddr, KData, KRead, KWait, KWp, KRb, KNoOe} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] val;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic void add(input kind_t k, input logic [7:0] v, input logic [7:0] e);
    vec_t t;
    t.kind = k; t.val = v; t.exp = e;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic we_cycle(input logic cle, input logic ale, input logic [7:0] v);
    bus.CLE_x = cle; bus.ALE_x = ale; bus.io_in = v; bus.WE_x_n = 1'b0;
    tick();
    bus.WE_x_n = 1'b1;
    tick();
    bus.CLE_x = 1'b0; bus.ALE_x = 1'b0;
  endtask

  task automatic rd(output logic [7:0] d, output logic oe);
    bus.RE_x_n = 1'b0;
    tick();
    d = bus.io_out; oe = bus.io_oe;
    bus.RE_x_n = 1'b1;
    tick();
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [7:0] d;
    logic       oe;
    int         n;
    case (v.kind)
      KCmd:  we_cycle(1'b1, 1'b0, v.val);
      KAddr: we_cycle(1'b0, 1'b1, v.val);
      KData: we_cycle(1'b0, 1'b0, v.val);
      KRead: begin
        rd(d, oe);
        check({tag, " read"}, {7'b0, oe, d}, {8'h01, v.exp});
      end
      KNoOe: begin
        rd(d, oe);
        check({tag, " io_oe idle"}, {15'b0, oe}, 16'h0000);
      end
      KWait: begin
        n = 0;
        while (bus.RB_x_n === 1'b0 && n < 1000) begin
          n++;
          tick();
        end
        check({tag, " busy cycles"}, 16'(n), 16'(v.exp));
      end
      KWp: bus.WP_x_n = v.val[0];
      KRb: check({tag, " RB_x_n"}, {15'b0, bus.RB_x_n}, {15'b0, v.val[0]});
      default: ;
    endcase
  endtask

  task automatic op(input kind_t k, input logic [7:0] v, input logic [7:0] e, input string tag);
    vec_t t;
    t.kind = k; t.val = v; t.exp = e;
    apply(t, tag);
  endtask

  initial begin
    logic [7:0] d;
    logic       oe, rb_now;
    int         n80, nrd;

    bus.CE_x_n = 1'b0; bus.CLE_x = 1'b0; bus.ALE_x = 1'b0; bus.WE_x_n = 1'b1;
    bus.RE_x_n = 1'b1; bus.WP_x_n = 1'b1; bus.io_in = 8'h00;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset RB_x_n", {15'b0, bus.RB_x_n}, 16'h0001);
    check("reset io_oe", {15'b0, bus.io_oe}, 16'h0000);
    check("reset io_out", {8'h00, bus.io_out}, 16'h0000);

    // READ ID with wrap, then a rejected ID address
    add(KCmd, 8'h90, 0); add(KAddr, 8'h00, 0);
    add(KRead, 0, 8'h2C); add(KRead, 0, 8'hDA); add(KRead, 0, 8'h90);
    add(KRead, 0, 8'h95); add(KRead, 0, 8'h2C);
    add(KCmd, 8'h90, 0); add(KAddr, 8'h01, 0); add(KNoOe, 0, 0);
    // 0x30 without both address cycles is ignored
    add(KCmd, 8'h00, 0); add(KAddr, 8'h05, 0); add(KCmd, 8'h30, 0); add(KRb, 8'h01, 0);
    // erased read of row 1 from col 3, 17 bytes across the wrap
    add(KCmd, 8'h00, 0); add(KAddr, 8'h03, 0); add(KAddr, 8'h01, 0);
    add(KCmd, 8'h30, 0); add(KWait, 0, 8'(TR));
    for (int i = 0; i < 17; i++) add(KRead, 0, 8'hFF);
    // program row 2 at col 14 (wraps to cols 0,1)
    add(KCmd, 8'h80, 0); add(KAddr, 8'h0E, 0); add(KAddr, 8'h02, 0);
    add(KData, 8'hA0, 0); add(KData, 8'hA1, 0); add(KData, 8'hA2, 0); add(KData, 8'hA3, 0);
    add(KCmd, 8'h10, 0); add(KWait, 0, 8'(TP));
    add(KCmd, 8'h70, 0); add(KRead, 0, 8'hE0);
    // read back with upper address bits set and a surplus third address cycle
    add(KCmd, 8'h00, 0); add(KAddr, 8'hFE, 0); add(KAddr, 8'h12, 0); add(KAddr, 8'h01, 0);
    add(KCmd, 8'h30, 0); add(KWait, 0, 8'(TR));
    add(KRead, 0, 8'hA0); add(KRead, 0, 8'hA1); add(KRead, 0, 8'hA2);
    add(KRead, 0, 8'hA3); add(KRead, 0, 8'hFF);
    // write-protected program of row 3
    add(KWp, 8'h00, 0);
    add(KCmd, 8'h80, 0); add(KAddr, 8'h00, 0); add(KAddr, 8'h03, 0);
    add(KData, 8'h12, 0); add(KData, 8'h34, 0);
    add(KCmd, 8'h10, 0); add(KWait, 0, 8'(TP));
    add(KCmd, 8'h70, 0); add(KRead, 0, 8'h61);
    add(KWp, 8'h01, 0);
    add(KCmd, 8'h00, 0); add(KAddr, 8'h00, 0); add(KAddr, 8'h03, 0);
    add(KCmd, 8'h30, 0); add(KWait, 0, 8'(TR));
    add(KRead, 0, 8'hFF); add(KRead, 0, 8'hFF);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Abort a program 10 cycles in with RESET
    op(KCmd, 8'h80, 0, "abort"); op(KAddr, 8'h00, 0, "abort"); op(KAddr, 8'h00, 0, "abort");
    op(KData, 8'h55, 0, "abort"); op(KData, 8'h66, 0, "abort");
    op(KCmd, 8'h10, 0, "abort");
    for (int i = 0; i < 8; i++) tick();
    check("abort still busy", {15'b0, bus.RB_x_n}, 16'h0000);
    op(KCmd, 8'hFF, 0, "abort");
    op(KWait, 0, 8'(TRST), "abort rst");
    op(KCmd, 8'h70, 0, "abort"); op(KRead, 0, 8'hE0, "abort status");
    op(KCmd, 8'h00, 0, "abort"); op(KAddr, 8'h00, 0, "abort"); op(KAddr, 8'h00, 0, "abort");
    op(KCmd, 8'h30, 0, "abort"); op(KWait, 0, 8'(TR), "abort rd");
    op(KRead, 0, 8'hFF, "abort row0"); op(KRead, 0, 8'hFF, "abort row0");

    // Status polled during T_R, then bare 0x00 resumes page data at col 14
    op(KCmd, 8'h00, 0, "poll"); op(KAddr, 8'h0E, 0, "poll"); op(KAddr, 8'h02, 0, "poll");
    op(KCmd, 8'h30, 0, "poll");
    for (int i = 0; i < 3; i++) tick();
    op(KCmd, 8'h70, 0, "poll");
    n80 = 0; nrd = 0;
    do begin
      rb_now = bus.RB_x_n;
      rd(d, oe);
      nrd++;
      check($sformatf("poll status %0d", nrd), {7'b0, oe, d}, {8'h01, rb_now ? 8'hE0 : 8'h80});
      if (!rb_now) n80++;
    end while (!rb_now && nrd < 40);
    check("poll saw busy status", 16'(n80 > 0), 16'h0001);
    check("poll ended ready", {15'b0, rb_now}, 16'h0001);
    op(KCmd, 8'h00, 0, "resume");
    op(KRead, 0, 8'hA0, "resume"); op(KRead, 0, 8'hA1, "resume");
    op(KRead, 0, 8'hA2, "resume"); op(KRead, 0, 8'hA3, "resume");

    // Chip enable high: RE ignored, state and ID index retained
    op(KCmd, 8'h90, 0, "ce"); op(KAddr, 8'h00, 0, "ce");
    bus.CE_x_n = 1'b1;
    op(KNoOe, 0, 0, "ce high");
    bus.CE_x_n = 1'b0;
    op(KRead, 0, 8'h2C, "ce back"); op(KRead, 0, 8'hDA, "ce back");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
